// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and types for the instruction-fetch stage
// Purpose: phase-bus indices, fault codes, fetch FSM state encoding, NOP encoding
// and the wait-timer width. No ports.
package fetch_unit_pkg;

    // One-hot phase bus layout driven by the phase sequencer
    localparam int PHASE_W = 5;
    localparam int PH_F    = 0;
    localparam int PH_D    = 1;
    localparam int PH_E    = 2;
    localparam int PH_M    = 3;
    localparam int PH_W    = 4;

    // Instruction-register value after reset
    localparam logic [31:0] NOP_INSN = 32'h0000_0000;

    // Wide enough for the largest legal TIMEOUT (255)
    localparam int TIMER_W = 8;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_TIMEOUT  = 2'b10
    } fault_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_DONE  = 2'b10,
        ST_FAULT = 2'b11
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory read handshake bundle
// Purpose: groups the single-word read request/acknowledge bus.
// Signals: imem_req (request), imem_addr (word address), imem_ack (data valid),
//          imem_rdata (instruction word).
// Modports: master = fetch side, slave = memory side.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_timer.sv
// rtl/fetch_timer.sv - wait counter bounding how long a fetch request may stay unacknowledged
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   clr_i        force the count to zero (takes priority over en_i)
//   en_i         increment the count
//   expired_o    count has reached TIMEOUT-1
module fetch_timer
    import fetch_unit_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TIMER_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + TIMER_W'(1);
        end
    end

    assign expired_o = (cnt_q == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction-fetch stage: one memory read per entry into the F phase
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   phase         one-hot phase bus from the sequencer
//   pc_reg        committed program counter
//   imem          instruction-memory read bus (master side)
//   ir, ir_valid  instruction register and its valid flag
//   pc_plus4      fetched address + 4, for the next-PC mux
//   fetch_done    one-cycle pulse when ir loads
//   fetch_stall   hold the sequencer in F
//   fetch_fault   sticky fault code (none / misaligned / timeout)
module fetch_unit #(
    parameter int          PHASE_W  = fetch_unit_pkg::PHASE_W,
    parameter int          F_IDX    = fetch_unit_pkg::PH_F,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] RESET_IR = fetch_unit_pkg::NOP_INSN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] phase,
    input  logic [31:0]        pc_reg,
    fetch_unit_if.master       imem,
    output logic [31:0]        ir,
    output logic               ir_valid,
    output logic [31:0]        pc_plus4,
    output logic               fetch_done,
    output logic               fetch_stall,
    output logic [1:0]         fetch_fault
);

    import fetch_unit_pkg::*;

    fetch_state_e state_q;
    fault_e       fault_q;
    logic         req_q;
    logic [31:0]  addr_q;
    logic [31:0]  pc_plus4_q;
    logic [31:0]  ir_q;
    logic         ir_valid_q;
    logic         done_q;
    logic         phase_f_q;

    logic phase_f;
    logic fetch_start;
    logic timer_clr;
    logic timer_en;
    logic timer_expired;

    // Only the fetch bit of the phase bus matters here
    logic unused_phase_bits;
    assign unused_phase_bits = ^phase;

    assign phase_f = phase[F_IDX];

    // Rising edge of F: holding F across instructions does not refetch
    assign fetch_start = phase_f && !phase_f_q;

    // The counter sits at zero outside REQ, so each request starts from zero
    assign timer_clr = (state_q != ST_REQ);
    assign timer_en  = (state_q == ST_REQ) && !imem.imem_ack;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_fetch_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fault_q    <= FAULT_NONE;
            req_q      <= 1'b0;
            addr_q     <= 32'h0000_0000;
            pc_plus4_q <= 32'h0000_0004;
            ir_q       <= RESET_IR;
            ir_valid_q <= 1'b0;
            done_q     <= 1'b0;
            phase_f_q  <= 1'b0;
        end else begin
            phase_f_q <= phase_f;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fetch_start) begin
                        ir_valid_q <= 1'b0;
                        if (pc_reg[1:0] == 2'b00) begin
                            state_q    <= ST_REQ;
                            req_q      <= 1'b1;
                            addr_q     <= pc_reg;
                            pc_plus4_q <= pc_reg + 32'd4;
                        end else begin
                            state_q <= ST_FAULT;
                            fault_q <= FAULT_MISALIGN;
                        end
                    end
                end
                ST_REQ: begin
                    if (imem.imem_ack) begin
                        state_q    <= ST_DONE;
                        req_q      <= 1'b0;
                        ir_q       <= imem.imem_rdata;
                        ir_valid_q <= 1'b1;
                        done_q     <= 1'b1;
                    end else if (timer_expired) begin
                        state_q <= ST_FAULT;
                        fault_q <= FAULT_TIMEOUT;
                        req_q   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    // ir stays valid through the remaining phases
                    if (!phase_f) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    // Terminal until reset
                    req_q      <= 1'b0;
                    ir_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign ir             = ir_q;
    assign ir_valid       = ir_valid_q;
    assign pc_plus4       = pc_plus4_q;
    assign fetch_done     = done_q;
    assign fetch_fault    = fault_q;
    assign fetch_stall    = (phase_f && (state_q != ST_DONE)) || (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit (TIMEOUT=16 and TIMEOUT=4 instances)
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  phase = 5'b0;
    logic [31:0] pc_reg = 32'h0;

    fetch_unit_if ifa ();
    fetch_unit_if ifb ();

    logic [31:0] a_ir, a_pc_plus4, b_ir, b_pc_plus4;
    logic        a_ir_valid, a_done, a_stall, b_ir_valid, b_done, b_stall;
    logic [1:0]  a_fault, b_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.TIMEOUT(16)) u_a (
        .clk(clk), .rst(rst), .phase(phase), .pc_reg(pc_reg), .imem(ifa),
        .ir(a_ir), .ir_valid(a_ir_valid), .pc_plus4(a_pc_plus4),
        .fetch_done(a_done), .fetch_stall(a_stall), .fetch_fault(a_fault)
    );

    fetch_unit #(.TIMEOUT(4)) u_b (
        .clk(clk), .rst(rst), .phase(phase), .pc_reg(pc_reg), .imem(ifb),
        .ir(b_ir), .ir_valid(b_ir_valid), .pc_plus4(b_pc_plus4),
        .fetch_done(b_done), .fetch_stall(b_stall), .fetch_fault(b_fault)
    );

    // Expected outcome of one fetch from the stated rules:
    // misaligned -> no request, fault 01; ack after d idle cycles within the
    // timeout -> d+1 request cycles, ir loaded d+2 edges after F rises;
    // otherwise -> tmo request cycles then fault 10.
    task automatic model_fetch(input logic [31:0] pc, input int d, input int tmo,
                               output int req_n, output int lat, output logic [1:0] fault);
        if (pc[1:0] != 2'b00) begin
            req_n = 0; lat = -1; fault = 2'b01;
        end else if (d < tmo) begin
            req_n = d + 1; lat = d + 2; fault = 2'b00;
        end else begin
            req_n = tmo; lat = -1; fault = 2'b10;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        phase = 5'b0;
        ifa.imem_ack = 1'b0;
        ifb.imem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Enters F with pc, plays a memory that acks after d request cycles, and
    // records what it saw; leaves the phase bus in D on return.
    task automatic run_fetch(input bit use_b, input logic [31:0] pc, input int d,
                             input logic [31:0] rdata, input int max_cycles,
                             output int req_n, output int lat, output int pulses,
                             output int addr_bad, output int stall_bad);
        logic        r_req, r_done, r_stall, hit;
        logic [31:0] r_addr;
        req_n = 0; lat = -1; pulses = 0; addr_bad = 0; stall_bad = 0;
        @(negedge clk);
        pc_reg = pc;
        phase  = 5'b00001;
        for (int c = 1; c <= max_cycles; c++) begin
            @(negedge clk);
            r_req   = use_b ? ifb.imem_req  : ifa.imem_req;
            r_addr  = use_b ? ifb.imem_addr : ifa.imem_addr;
            r_done  = use_b ? b_done  : a_done;
            r_stall = use_b ? b_stall : a_stall;
            if (r_done) begin
                pulses++;
                if (lat < 0) lat = c;
            end
            if (r_req) begin
                req_n++;
                if (r_addr !== pc) addr_bad++;
            end
            if (r_stall !== (lat < 0)) stall_bad++;
            hit = r_req && (req_n - 1 == d);
            if (use_b) begin
                ifb.imem_ack = hit; ifb.imem_rdata = hit ? rdata : ~rdata;
            end else begin
                ifa.imem_ack = hit; ifa.imem_rdata = hit ? rdata : ~rdata;
            end
        end
        ifa.imem_ack = 1'b0;
        ifb.imem_ack = 1'b0;
        phase = 5'b00010;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ifa.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", ifa.imem_req); end
        checks++; if (ifa.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", ifa.imem_addr); end
        checks++; if (a_pc_plus4 !== 32'h4) begin errors++; $display("FAIL reset_pc4 got=%h exp=4", a_pc_plus4); end
        checks++; if (a_ir !== 32'h0) begin errors++; $display("FAIL reset_ir got=%h exp=0", a_ir); end
        checks++; if (a_ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", a_ir_valid); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", a_done); end
        checks++; if (a_fault !== 2'b00) begin errors++; $display("FAIL reset_fault got=%b exp=00", a_fault); end
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", a_stall); end
    endtask

    task automatic test_first_cycle_ack();
        int rq, lat, pl, ab, sb, erq, elat;
        logic [1:0] ef;
        model_fetch(32'h100, 0, 16, erq, elat, ef);
        run_fetch(1'b0, 32'h100, 0, 32'h8C220004, 6, rq, lat, pl, ab, sb);
        checks++; if (rq !== erq) begin errors++; $display("FAIL first_req_cycles got=%0d exp=%0d", rq, erq); end
        checks++; if (lat !== elat) begin errors++; $display("FAIL first_latency got=%0d exp=%0d", lat, elat); end
        checks++; if (pl !== 1) begin errors++; $display("FAIL first_done_pulses got=%0d exp=1", pl); end
        checks++; if (ab !== 0 || sb !== 0) begin errors++; $display("FAIL first_addr_stall got=%0d/%0d exp=0/0", ab, sb); end
        checks++; if (ifa.imem_addr !== 32'h100) begin errors++; $display("FAIL first_addr got=%h exp=100", ifa.imem_addr); end
        checks++; if (a_pc_plus4 !== 32'h104) begin errors++; $display("FAIL first_pc4 got=%h exp=104", a_pc_plus4); end
        checks++; if (a_ir !== 32'h8C220004) begin errors++; $display("FAIL first_ir got=%h exp=8c220004", a_ir); end
        @(negedge clk);
        checks++; if (a_ir_valid !== 1'b1 || a_stall !== 1'b0) begin errors++; $display("FAIL first_valid_after_F got=%b/%b exp=1/0", a_ir_valid, a_stall); end
    endtask

    task automatic test_delayed_ack();
        int rq, lat, pl, ab, sb, erq, elat;
        logic [1:0]  ef;
        logic [31:0] rd;
        @(negedge clk);
        ifa.imem_ack = 1'b1; ifa.imem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        ifa.imem_ack = 1'b0;
        checks++; if (a_ir !== 32'h8C220004) begin errors++; $display("FAIL stray_ack_ir got=%h exp=8c220004", a_ir); end
        rd = $urandom;
        model_fetch(32'h200, 5, 16, erq, elat, ef);
        run_fetch(1'b0, 32'h200, 5, rd, 12, rq, lat, pl, ab, sb);
        checks++; if (rq !== erq) begin errors++; $display("FAIL delay_req_cycles got=%0d exp=%0d", rq, erq); end
        checks++; if (lat !== elat) begin errors++; $display("FAIL delay_latency got=%0d exp=%0d", lat, elat); end
        checks++; if (ab !== 0) begin errors++; $display("FAIL delay_addr_stable got=%0d exp=0", ab); end
        checks++; if (sb !== 0) begin errors++; $display("FAIL delay_stall got=%0d exp=0", sb); end
        checks++; if (a_ir !== rd) begin errors++; $display("FAIL delay_ir got=%h exp=%h", a_ir, rd); end
    endtask

    task automatic test_misalign();
        int rq, lat, pl, ab, sb, erq, elat;
        logic [1:0]  ef;
        logic [31:0] ir_before;
        ir_before = a_ir;
        model_fetch(32'h102, 0, 16, erq, elat, ef);
        run_fetch(1'b0, 32'h102, 0, 32'h11111111, 6, rq, lat, pl, ab, sb);
        checks++; if (rq !== erq) begin errors++; $display("FAIL mis_req_cycles got=%0d exp=%0d", rq, erq); end
        checks++; if (a_fault !== ef) begin errors++; $display("FAIL mis_fault got=%b exp=%b", a_fault, ef); end
        checks++; if (sb !== 0 || a_stall !== 1'b1) begin errors++; $display("FAIL mis_stall got=%0d/%b exp=0/1", sb, a_stall); end
        run_fetch(1'b0, 32'h300, 0, 32'h22222222, 6, rq, lat, pl, ab, sb);
        checks++; if (rq !== 0 || pl !== 0) begin errors++; $display("FAIL mis_reentry got=%0d/%0d exp=0/0", rq, pl); end
        checks++; if (a_fault !== 2'b01 || a_ir !== ir_before || a_ir_valid !== 1'b0) begin
            errors++; $display("FAIL mis_sticky got=%b/%h/%b exp=01/%h/0", a_fault, a_ir, a_ir_valid, ir_before);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        int rq, lat, pl, ab, sb, erq, elat;
        logic [1:0] ef;
        do_reset();
        model_fetch(32'h40, 1000, 4, erq, elat, ef);
        run_fetch(1'b1, 32'h40, 1000, 32'h0, 10, rq, lat, pl, ab, sb);
        checks++; if (rq !== erq) begin errors++; $display("FAIL tmo_req_cycles got=%0d exp=%0d", rq, erq); end
        checks++; if (b_fault !== ef || ifb.imem_req !== 1'b0) begin errors++; $display("FAIL tmo_fault got=%b/%b exp=%b/0", b_fault, ifb.imem_req, ef); end
        @(negedge clk);
        ifb.imem_ack = 1'b1; ifb.imem_rdata = 32'h12345678;
        @(negedge clk);
        ifb.imem_ack = 1'b0;
        checks++; if (b_ir !== 32'h0 || b_ir_valid !== 1'b0 || b_fault !== 2'b10) begin
            errors++; $display("FAIL tmo_late_ack got=%h/%b/%b exp=0/0/10", b_ir, b_ir_valid, b_fault);
        end
        do_reset();
    endtask

    task automatic test_wrap();
        int rq, lat, pl, ab, sb;
        run_fetch(1'b0, 32'hFFFFFFFC, 1, 32'h0, 6, rq, lat, pl, ab, sb);
        checks++; if (a_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got=%h exp=0", a_pc_plus4); end
        checks++; if (a_ir_valid !== 1'b1 || a_ir !== 32'h0) begin errors++; $display("FAIL wrap_ir got=%b/%h exp=1/0", a_ir_valid, a_ir); end
    endtask

    task automatic test_reset_mid_req();
        int rq, lat, pl, ab, sb, d;
        logic [31:0] rd;
        @(negedge clk);
        pc_reg = 32'h400; phase = 5'b00001;
        repeat (2) @(negedge clk);
        checks++; if (ifa.imem_req !== 1'b1) begin errors++; $display("FAIL midrst_req_before got=%b exp=1", ifa.imem_req); end
        #2 rst = 1'b0;
        #1;
        checks++; if (ifa.imem_req !== 1'b0 || ifa.imem_addr !== 32'h0) begin errors++; $display("FAIL midrst_bus got=%b/%h exp=0/0", ifa.imem_req, ifa.imem_addr); end
        checks++; if (a_pc_plus4 !== 32'h4 || a_ir_valid !== 1'b0 || a_fault !== 2'b00) begin
            errors++; $display("FAIL midrst_regs got=%h/%b/%b exp=4/0/00", a_pc_plus4, a_ir_valid, a_fault);
        end
        phase = 5'b0;
        @(negedge clk);
        rst = 1'b1;
        d = $urandom_range(0, 5);
        rd = $urandom;
        run_fetch(1'b0, 32'h0, d, rd, 10, rq, lat, pl, ab, sb);
        checks++; if (lat !== d + 2 || a_ir !== rd || a_pc_plus4 !== 32'h4) begin
            errors++; $display("FAIL midrst_refetch got=%0d/%h/%h exp=%0d/%h/4", lat, a_ir, a_pc_plus4, d + 2, rd);
        end
    endtask

    task automatic test_random();
        int rq, lat, pl, ab, sb, erq, elat, d;
        logic [1:0]  ef;
        logic [31:0] pc, rd;
        for (int i = 0; i < 24; i++) begin
            pc = $urandom;
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            d  = $urandom_range(0, 18);
            rd = $urandom;
            model_fetch(pc, d, 16, erq, elat, ef);
            run_fetch(1'b0, pc, d, rd, 22, rq, lat, pl, ab, sb);
            checks++; if (rq !== erq || lat !== elat) begin errors++; $display("FAIL rnd%0d_timing got=%0d/%0d exp=%0d/%0d", i, rq, lat, erq, elat); end
            checks++; if (pl !== ((elat >= 0) ? 1 : 0) || ab !== 0 || sb !== 0) begin errors++; $display("FAIL rnd%0d_proto got=%0d/%0d/%0d", i, pl, ab, sb); end
            checks++; if (a_fault !== ef) begin errors++; $display("FAIL rnd%0d_fault got=%b exp=%b", i, a_fault, ef); end
            if (elat >= 0) begin
                checks++; if (a_ir !== rd || a_pc_plus4 !== pc + 32'd4) begin
                    errors++; $display("FAIL rnd%0d_data got=%h/%h exp=%h/%h", i, a_ir, a_pc_plus4, rd, pc + 32'd4);
                end
            end else begin
                do_reset();
            end
        end
    endtask

    initial begin
        ifa.imem_ack = 1'b0; ifa.imem_rdata = 32'h0;
        ifb.imem_ack = 1'b0; ifb.imem_rdata = 32'h0;
        test_reset();
        test_first_cycle_ack();
        test_delayed_ack();
        test_misalign();
        test_timeout();
        test_wrap();
        test_reset_mid_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that consumes the committed program counter (pc_reg) and the one-hot phase bus.
- On entry to the fetch phase it issues a single-word read to instruction memory over a req/ack handshake, then latches the returned word into the instruction register.
- Drives fetch_stall so the phase sequencer holds the F phase until the word arrives.
- Produces pc_plus4, which the next-PC mux returns to the PC register for the write-back phase.

Parameters:
- PHASE_W, 5, width of the one-hot phase bus (F=0, D=1, E=2, M=3, W=4).
- F_IDX, 0, bit index of the fetch phase within the phase bus.
- TIMEOUT, 16, maximum REQ cycles without imem_ack before a timeout fault; legal range 2..255.
- RESET_IR, 32'h00000000, instruction-register reset value (NOP encoding).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- phase  in  PHASE_W  one-hot phase from the sequencer.
- pc_reg  in  32  current program counter.
- imem_ack  in  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  in  32  instruction word; sampled only when imem_req && imem_ack.
- imem_req  out  1  read request, registered.
- imem_addr  out  32  word address, registered; equals pc_reg captured at fetch start.
- ir  out  32  instruction register.
- ir_valid  out  1  ir holds the word for the current fetch.
- pc_plus4  out  32  imem_addr + 4, registered alongside imem_addr.
- fetch_done  out  1  one-cycle pulse when ir is loaded.
- fetch_stall  out  1  sequencer must hold phase in F.
- fetch_fault  out  2  sticky fault code: 00 none, 01 misaligned PC, 10 timeout.

Behaviour:
- Reset (rst=0, async): state=IDLE, imem_req=0, imem_addr=0, pc_plus4=4, ir=RESET_IR, ir_valid=0, fetch_done=0, fetch_fault=00, wait counter=0, phase-F history flop=0.
- Fetch start = phase[F_IDX]=1 && history flop=0. The flop registers phase[F_IDX] every cycle.
- IDLE:
  - On fetch start with pc_reg[1:0]==0: go to REQ; next edge sets imem_req=1, imem_addr=pc_reg, pc_plus4=pc_reg+4 (mod 2^32; 0xFFFFFFFC gives 0), ir_valid=0, counter=0.
  - On fetch start with pc_reg[1:0]!=0: go to FAULT, fetch_fault=01, no request issued.
- REQ:
  - imem_req=1, imem_addr held stable.
  - On imem_ack: ir<=imem_rdata, ir_valid<=1, fetch_done<=1 for one cycle, imem_req<=0, go to DONE.
  - Otherwise counter increments; when the counter reaches TIMEOUT-1 without ack: go to FAULT, fetch_fault=10, imem_req<=0.
  - Ack on the first REQ cycle is legal.
  - Minimum latency: fetch start at edge N, ir_valid at edge N+2.
- DONE: ir and ir_valid held. When phase[F_IDX]=0, go to IDLE; ir stays valid through D/E/M/W.
- FAULT: terminal until reset. imem_req=0, ir_valid=0, fetch_stall=1, code held.
- fetch_stall = phase[F_IDX] && state!=DONE, OR state==FAULT. Combinational from state and phase.
- imem_ack outside REQ is ignored (no ir update).
- Phase leaving F while in REQ is a sequencer protocol error. The request continues and completes normally; no new fetch starts until F is re-entered.
- F held across consecutive instructions without deassertion: no new fetch starts. The sequencer must drop F between instructions.
- Reset mid-REQ: imem_req drops immediately (async). The memory must tolerate an abandoned request.
- Only one outstanding request at any time.

Decomposition:
- Shared package/defines:
  - phase indices (F/D/E/M/W) and PHASE_W.
  - fault codes FAULT_NONE / FAULT_MISALIGN / FAULT_TIMEOUT.
  - fetch state encoding (IDLE, REQ, DONE, FAULT).
  - NOP encoding used for RESET_IR.
- Sub-module fetch_timer: the wait counter with clear, enable, and an expired flag at TIMEOUT-1. Keeps the FSM readable.
- All other logic stays in fetch_unit.

Test Plan:
- Reset then F entry, pc_reg=0x00000100, ack on first REQ cycle with rdata=0x8C220004:
  - imem_addr=0x100, pc_plus4=0x104.
  - ir=0x8C220004 and fetch_done pulses at edge N+2.
  - fetch_stall drops when ir_valid rises.
- pc_reg=0x00000200, ack delayed 5 cycles:
  - imem_req high for exactly 6 cycles, addr stable throughout.
  - fetch_stall high until ir loads.
  - a stray ack pulse in IDLE before the fetch leaves ir unchanged.
- pc_reg=0x00000102 at F entry:
  - imem_req never asserts, fetch_fault=01, fetch_stall stays 1.
  - a new F entry is ignored until reset.
- TIMEOUT=4, no ack:
  - imem_req high for 4 cycles, then fetch_fault=10 and imem_req=0.
  - a later ack is ignored.
- pc_reg=0xFFFFFFFC, ack with 0x00000000: pc_plus4=0x00000000, ir_valid=1.
- Assert rst during REQ:
  - imem_req=0 combinationally, all outputs at reset values.
  - after release, a normal fetch at pc_reg=0 completes.
